// File: rtl/rps_pkg.sv
// Shared encodings for the rock-paper-scissors match controller:
// move codes, round result codes and the controller FSM state type.
package rps_pkg;

   // Player move encodings
   localparam logic [1:0] ROCK     = 2'b00;
   localparam logic [1:0] PAPER    = 2'b01;
   localparam logic [1:0] SCISSORS = 2'b10;
   localparam logic [1:0] INVALID  = 2'b11;

   // Round result codes driven on round_winner
   localparam logic [1:0] TIE   = 2'b00;
   localparam logic [1:0] A_WIN = 2'b01;
   localparam logic [1:0] B_WIN = 2'b10;
   localparam logic [1:0] ERR   = 2'b11;

   // Controller FSM states
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      JUDGE   = 3'd2,
      REPORT  = 3'd3,
      DONE    = 3'd4
   } state_t;

endpackage

// File: rtl/rps_judge.sv
// Purely combinational referee: classifies one pair of moves as an
// error (either move invalid), a tie, or an A win (otherwise a B win).
module rps_judge
   import rps_pkg::*;
(
   input  logic [1:0] a_move,
   input  logic [1:0] b_move,
   output logic       is_error,
   output logic       is_tie,
   output logic       is_a_win
);

   // Rock beats scissors, paper beats rock, scissors beats paper
   always_comb begin
      is_error = (a_move == INVALID) || (b_move == INVALID);
      is_tie   = !is_error && (a_move == b_move);
      is_a_win = !is_error &&
                 (((a_move == ROCK)     && (b_move == SCISSORS)) ||
                  ((a_move == PAPER)    && (b_move == ROCK))     ||
                  ((a_move == SCISSORS) && (b_move == PAPER)));
   end

endmodule

// File: rtl/rps_match_controller.sv
// Rock-paper-scissors match controller. Collects one move from each
// player over independent valid/ready handshakes, judges the round,
// reports the result and keeps score until one player reaches WIN_TARGET.
// Optional feature macro: RPS_TIMEOUT_EN (collect-phase timeout).
//
// Handshake: a move is transferred on a rising edge where valid && ready.
// ready depends only on controller state, never on valid, and drops once
// that player's move has been captured for the current round.
module rps_match_controller
   import rps_pkg::*;
#(
   parameter int WIN_TARGET     = 3,
   parameter int SCORE_W        = 3,
   parameter int TIMEOUT_CYCLES = 255
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               a_valid,
   input  logic [1:0]         a_move,
   output logic               a_ready,
   input  logic               b_valid,
   input  logic [1:0]         b_move,
   output logic               b_ready,
   output logic               busy,
   output logic               result_valid,
   output logic [1:0]         round_winner,
   output logic [SCORE_W-1:0] score_a,
   output logic [SCORE_W-1:0] score_b,
   output logic               match_done,
   output logic               match_winner,
   output state_t             state
);

   // Elaboration-time parameter sanity checks
   if (WIN_TARGET < 1 || WIN_TARGET > 7) begin : g_bad_target
      $error("WIN_TARGET must be in 1..7");
   end
   if ((2 ** SCORE_W) <= WIN_TARGET) begin : g_bad_score_w
      $error("SCORE_W too narrow for WIN_TARGET");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WIN_TARGET);

   logic       a_cap, b_cap;
   logic [1:0] a_mv, b_mv;
   logic       a_hs, b_hs;
   logic       is_error, is_tie, is_a_win;
   logic       timeout_hit;
   logic [1:0] next_winner;

   assign a_ready = (state == COLLECT) && !a_cap;
   assign b_ready = (state == COLLECT) && !b_cap;
   assign a_hs    = a_valid && a_ready;
   assign b_hs    = b_valid && b_ready;
   assign busy    = (state == COLLECT) || (state == JUDGE) || (state == REPORT);

   rps_judge u_judge (
      .a_move   (a_mv),
      .b_move   (b_mv),
      .is_error (is_error),
      .is_tie   (is_tie),
      .is_a_win (is_a_win)
   );

`ifdef RPS_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tcount;

   assign timeout_hit = (state == COLLECT) && (tcount == TW'(TIMEOUT_CYCLES - 1));

   // Count cycles spent in COLLECT; held at zero elsewhere so every entry restarts it
   always_ff @(posedge clk) begin
      if (!rst_n || state != COLLECT) tcount <= '0;
      else                            tcount <= tcount + 1'b1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Round outcome; partial captures only reach JUDGE through a timeout
   always_comb begin
      next_winner = TIE;
      if (a_cap && b_cap) begin
         if (is_error)      next_winner = ERR;
         else if (is_tie)   next_winner = TIE;
         else if (is_a_win) next_winner = A_WIN;
         else               next_winner = B_WIN;
      end else if (a_cap) begin
         next_winner = (a_mv == INVALID) ? ERR : A_WIN;
      end else if (b_cap) begin
         next_winner = (b_mv == INVALID) ? ERR : B_WIN;
      end
   end

   // Match FSM with capture flags, scores and registered result outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         a_cap        <= 1'b0;
         b_cap        <= 1'b0;
         a_mv         <= ROCK;
         b_mv         <= ROCK;
         score_a      <= '0;
         score_b      <= '0;
         result_valid <= 1'b0;
         round_winner <= TIE;
         match_done   <= 1'b0;
         match_winner <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  score_a      <= '0;
                  score_b      <= '0;
                  a_cap        <= 1'b0;
                  b_cap        <= 1'b0;
                  match_done   <= 1'b0;
                  match_winner <= 1'b0;
                  state        <= COLLECT;
               end
            end
            COLLECT: begin
               if (a_hs) begin
                  a_cap <= 1'b1;
                  a_mv  <= a_move;
               end
               if (b_hs) begin
                  b_cap <= 1'b1;
                  b_mv  <= b_move;
               end
               if (((a_cap || a_hs) && (b_cap || b_hs)) || timeout_hit)
                  state <= JUDGE;
            end
            JUDGE: begin
               round_winner <= next_winner;
               if (next_winner == A_WIN) score_a <= score_a + 1'b1;
               if (next_winner == B_WIN) score_b <= score_b + 1'b1;
               result_valid <= 1'b1;
               state        <= REPORT;
            end
            REPORT: begin
               if (score_a == TARGET || score_b == TARGET) begin
                  match_done   <= 1'b1;
                  match_winner <= (score_b == TARGET);
                  state        <= DONE;
               end else begin
                  a_cap <= 1'b0;
                  b_cap <= 1'b0;
                  state <= COLLECT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rps_match_controller.sv
// Self-checking bench for rps_match_controller: a directed vector table,
// hand-written reset/start/hold sequences, and randomized rounds checked
// against a modular-arithmetic reference of the game rules.
// Optional feature macro: RPS_TIMEOUT_EN (adds the collect timeout test).
module tb_rps_match_controller;
   import rps_pkg::*;

   localparam int WT = 3;
   localparam int SW = 3;
`ifdef RPS_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 255;
`endif

   logic          clk = 1'b0;
   logic          rst_n, start;
   logic          a_valid, b_valid, a_ready, b_ready;
   logic [1:0]    a_move, b_move, round_winner;
   logic          busy, result_valid, match_done, match_winner;
   logic [SW-1:0] score_a, score_b;
   state_t        state;

   rps_match_controller #(.WIN_TARGET(WT), .SCORE_W(SW), .TIMEOUT_CYCLES(TO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .a_valid      (a_valid),
      .a_move       (a_move),
      .a_ready      (a_ready),
      .b_valid      (b_valid),
      .b_move       (b_move),
      .b_ready      (b_ready),
      .busy         (busy),
      .result_valid (result_valid),
      .round_winner (round_winner),
      .score_a      (score_a),
      .score_b      (score_b),
      .match_done   (match_done),
      .match_winner (match_winner),
      .state        (state)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_sa  = 0;
   int exp_sb  = 0;
   bit match_over = 1'b1;

   typedef struct {
      logic [1:0] am;
      logic [1:0] bm;
      int         gap;    // >0: B offers later, <0: A offers later
      bit         noise;  // A keeps offering a different move after capture
      logic [1:0] exp_w;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference rule: (a - b) mod 3 is 0 for tie, 1 for A win, 2 for B win
   function automatic logic [1:0] ref_winner(input logic [1:0] am, input logic [1:0] bm);
      int d;
      if (am == 2'b11 || bm == 2'b11) return 2'b11;
      d = (int'(am) - int'(bm) + 3) % 3;
      return 2'(d);
   endfunction

   // Called at a negedge; the start pulse is sampled at the next rising edge
   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp_sa = 0;
      exp_sb = 0;
      match_over = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_scores", {16'(score_a), 16'(score_b)}, 32'd0);
   endtask

   // Drive both players until both moves are accepted; returns at the
   // negedge following the completing edge
   task automatic handshake(input logic [1:0] am, input logic [1:0] bm, input int gap,
                            input bit noise, output bit ok);
      int cyc  = 0;
      int a_st = (gap < 0) ? -gap : 0;
      int b_st = (gap > 0) ? gap : 0;
      bit ad   = 1'b0;
      bit bd   = 1'b0;
      ok = 1'b1;
      while (!(ad && bd)) begin
         a_valid = (cyc >= a_st) && (!ad || noise);
         a_move  = ad ? (am ^ 2'b01) : am;
         b_valid = (cyc >= b_st) && !bd;
         b_move  = bm;
         if (noise && ad) chk("a_ready_after_capture", 32'(a_ready), 32'd0);
         if (a_valid && a_ready && !ad) ad = 1'b1;
         if (b_valid && b_ready) bd = 1'b1;
         @(negedge clk);
         cyc++;
         if (cyc > 64) begin
            n_tests++;
            n_fail++;
            $display("FAIL handshake_timeout: got no accept in %0d cycles, required both accepted", cyc);
            ok = 1'b0;
            break;
         end
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   task automatic run_round(input logic [1:0] am, input logic [1:0] bm, input int gap,
                            input bit noise, input logic [1:0] exp_w);
      bit ok;
      if (match_over) do_start();
      handshake(am, bm, gap, noise, ok);
      if (!ok) return;
      chk("result_valid_early", 32'(result_valid), 32'd0);
      @(negedge clk);
      if (exp_w == A_WIN) exp_sa++;
      if (exp_w == B_WIN) exp_sb++;
      chk("result_valid", 32'(result_valid), 32'd1);
      chk("round_winner", 32'(round_winner), 32'(exp_w));
      chk("score_a", 32'(score_a), 32'(exp_sa));
      chk("score_b", 32'(score_b), 32'(exp_sb));
      @(negedge clk);
      if (exp_sa == WT || exp_sb == WT) begin
         match_over = 1'b1;
         chk("match_done", 32'(match_done), 32'd1);
         chk("done_busy", 32'(busy), 32'd0);
         chk("match_winner", 32'(match_winner), 32'(exp_sb == WT));
         chk("result_valid_pulse", 32'(result_valid), 32'd0);
      end else begin
         chk("back_in_collect", 32'(state), 32'(COLLECT));
         chk("ready_rearmed", {30'd0, a_ready, b_ready}, 32'd3);
         chk("result_valid_pulse", 32'(result_valid), 32'd0);
      end
   endtask

   initial begin
      bit ok;
      bit seen;
      int k;
      logic [1:0] ram, rbm;

      vecs[0]  = '{PAPER,    ROCK,     0, 1'b0, A_WIN};
      vecs[1]  = '{SCISSORS, SCISSORS, 5, 1'b0, TIE};
      vecs[2]  = '{INVALID,  ROCK,     2, 1'b1, ERR};
      vecs[3]  = '{ROCK,     SCISSORS, -1, 1'b0, A_WIN};
      vecs[4]  = '{SCISSORS, ROCK,     0, 1'b0, B_WIN};
      vecs[5]  = '{ROCK,     PAPER,    3, 1'b0, B_WIN};
      vecs[6]  = '{PAPER,    SCISSORS, 0, 1'b0, B_WIN};
      vecs[7]  = '{INVALID,  INVALID,  0, 1'b0, ERR};
      vecs[8]  = '{ROCK,     ROCK,     0, 1'b0, TIE};
      vecs[9]  = '{PAPER,    PAPER,    4, 1'b0, TIE};
      vecs[10] = '{SCISSORS, PAPER,    -2, 1'b0, A_WIN};
      vecs[11] = '{INVALID,  PAPER,    0, 1'b0, ERR};
      vecs[12] = '{ROCK,     INVALID,  3, 1'b1, ERR};

      rst_n = 1'b0; start = 1'b0;
      a_valid = 1'b0; a_move = 2'b00;
      b_valid = 1'b0; b_move = 2'b00;
      repeat (3) @(negedge clk);
      chk("rst_state", 32'(state), 32'(IDLE));
      chk("rst_ready", {30'd0, a_ready, b_ready}, 32'd0);
      chk("rst_flags", {29'd0, busy, result_valid, match_done}, 32'd0);
      chk("rst_scores", {16'(score_a), 16'(score_b)}, 32'd0);
      chk("rst_winners", {29'd0, round_winner, match_winner}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_no_ready", {30'd0, a_ready, b_ready}, 32'd0);

      // Directed table; start pulses mid-match and DONE hold checked in line
      for (int i = 0; i < 13; i++) begin
         run_round(vecs[i].am, vecs[i].bm, vecs[i].gap, vecs[i].noise, vecs[i].exp_w);
         if (i == 1) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("midmatch_start_state", 32'(state), 32'(COLLECT));
            chk("midmatch_start_scores", {16'(score_a), 16'(score_b)},
                {16'(exp_sa), 16'(exp_sb)});
         end
         if (i == 6) begin
            repeat (3) @(negedge clk);
            chk("done_hold_flags", {30'd0, match_done, match_winner}, 32'd3);
            chk("done_hold_scores", {16'(score_a), 16'(score_b)}, {16'd2, 16'd3});
            chk("done_hold_ready", {29'd0, a_ready, b_ready, busy}, 32'd0);
         end
      end

      // Randomized rounds against the reference rule
      for (int i = 0; i < 40; i++) begin
         ram = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         rbm = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         run_round(ram, rbm, int'($urandom_range(0, 6)) - 3, 1'($urandom_range(0, 1)),
                   ref_winner(ram, rbm));
      end

      // Reset while JUDGE is active: no result pulse, everything cleared
      if (match_over) do_start();
      handshake(PAPER, ROCK, 0, 1'b0, ok);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("judge_rst_state", 32'(state), 32'(IDLE));
      chk("judge_rst_scores", {16'(score_a), 16'(score_b)}, 32'd0);
      chk("judge_rst_flags", {29'd0, busy, result_valid, match_done}, 32'd0);
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         seen = seen | result_valid;
         @(negedge clk);
      end
      chk("judge_rst_no_result", 32'(seen), 32'd0);
      match_over = 1'b1;

`ifdef RPS_TIMEOUT_EN
      // Only A submits; the round must close after TO cycles in COLLECT
      do_start();
      a_valid = 1'b1;
      a_move  = ROCK;
      k = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         a_valid = 1'b0;
         if (result_valid) begin
            k = c;
            break;
         end
      end
      chk("timeout_latency", 32'(k), 32'(TO + 1));
      chk("timeout_winner", 32'(round_winner), 32'(A_WIN));
      chk("timeout_scores", {16'(score_a), 16'(score_b)}, {16'd1, 16'd0});
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
